// File: rtl/posit_pkg.sv
// posit_pkg: shared widths, special encodings and state encoding for the
// serial posit encoder/decoder pair (32-bit posits, es=3).
package posit_pkg;

    localparam int N     = 32;
    localparam int ES    = 3;
    localparam int K_W   = 6;
    localparam int IDX_W = 5;
    localparam int MS_W  = 5;

    localparam logic [N-1:0]   POSIT_ZERO = 32'h0000_0000;
    localparam logic [N-1:0]   POSIT_NAR  = 32'h8000_0000;
    localparam logic [K_W-1:0] RUN_MAX    = 6'd31;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SIGN   = 3'd1,
        ST_REGIME = 3'd2,
        ST_EXP    = 3'd3,
        ST_MANT   = 3'd4,
        ST_DONE   = 3'd5
    } posit_state_e;

endpackage

// File: rtl/posit_decoder_if.sv
// posit_decoder_if: start/done/received handshake, packed operand and
// decoded posit fields. master = operand/consumer side, slave = decoder.
interface posit_decoder_if;
    import posit_pkg::*;

    logic                  start;
    logic                  received;
    logic [N-1:0]          posit_in;
    logic                  sign_out;
    logic signed [K_W-1:0] k_out;
    logic [ES-1:0]         exp_out;
    logic [N-1:0]          mantissa_out;
    logic [MS_W-1:0]       mant_size;
    logic                  is_zero;
    logic                  is_nar;
    logic                  done;
    logic                  busy;

    modport master (
        output start, received, posit_in,
        input  sign_out, k_out, exp_out, mantissa_out, mant_size,
               is_zero, is_nar, done, busy
    );

    modport slave (
        input  start, received, posit_in,
        output sign_out, k_out, exp_out, mantissa_out, mant_size,
               is_zero, is_nar, done, busy
    );

endinterface

// File: rtl/posit_decoder.sv
// posit_decoder: serial MSB-first decoder for 32-bit posits with es=3.
// Exactly one posit bit is consumed per cycle, so every operand takes the same
// number of cycles; results are held with done until the consumer acknowledges.
// Build macro POSIT_DEC_TWOS_COMP_EN: negative non-NaR operands are converted
// from two's complement at capture (fields decode as standard signed posits);
// left undefined, the raw sign-magnitude layout is decoded.
//
// state  | meaning
// IDLE   | waiting for start, last result held
// SIGN   | bit 31 -> sign, bit 30 -> regime polarity, special-value flags
// REGIME | count run of regime bits until terminator or LSB
// EXP    | up to three exponent bits, MSB first
// MANT   | remaining bits left-aligned into the mantissa
// DONE   | result valid (done raised one cycle after entry), wait for received
module posit_decoder
    import posit_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    posit_decoder_if.slave bus
);

    posit_state_e          state_q, state_d;
    logic [N-1:0]          word_q, word_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic                  pol_q, pol_d;
    logic [K_W-1:0]        run_q, run_d;
    logic [1:0]            exp_cnt_q, exp_cnt_d;

    logic                  sign_q, sign_d;
    logic signed [K_W-1:0] k_q, k_d;
    logic [ES-1:0]         exp_q, exp_d;
    logic [N-1:0]          mant_q, mant_d;
    logic [MS_W-1:0]       mant_size_q, mant_size_d;
    logic                  is_zero_q, is_zero_d;
    logic                  is_nar_q, is_nar_d;
    logic                  done_q, done_d;

    logic                  cur_bit;
    logic [K_W-1:0]        run_inc;
    logic [K_W-1:0]        run_fin;
    logic [N-1:0]          captured;

    assign cur_bit = word_q[index_q];
    assign run_inc = (run_q == RUN_MAX) ? RUN_MAX : run_q + 6'd1;

`ifdef POSIT_DEC_TWOS_COMP_EN
    // Low 31 bits of -posit_in depend only on the low 31 bits of posit_in.
    logic [N-2:0] neg_low;
    assign neg_low = ~bus.posit_in[N-2:0] + {{(N-2){1'b0}}, 1'b1};

    // Negative operands (other than NaR) are stored as sign + magnitude of the negation.
    always_comb begin
        captured = bus.posit_in;
        if (bus.posit_in[N-1] && (bus.posit_in != POSIT_NAR)) begin
            captured = {1'b1, neg_low};
        end
    end
`else
    assign captured = bus.posit_in;
`endif

    // State and result registers; reset parks the bit index at the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            index_q     <= 5'd31;
            pol_q       <= 1'b0;
            run_q       <= '0;
            exp_cnt_q   <= '0;
            sign_q      <= 1'b0;
            k_q         <= '0;
            exp_q       <= '0;
            mant_q      <= '0;
            mant_size_q <= '0;
            is_zero_q   <= 1'b0;
            is_nar_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            index_q     <= index_d;
            pol_q       <= pol_d;
            run_q       <= run_d;
            exp_cnt_q   <= exp_cnt_d;
            sign_q      <= sign_d;
            k_q         <= k_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            mant_size_q <= mant_size_d;
            is_zero_q   <= is_zero_d;
            is_nar_q    <= is_nar_d;
            done_q      <= done_d;
        end
    end

    // Next-state and field extraction: one bit of word_q[index_q] per cycle.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        index_d     = index_q;
        pol_d       = pol_q;
        run_d       = run_q;
        exp_cnt_d   = exp_cnt_q;
        sign_d      = sign_q;
        k_d         = k_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        mant_size_d = mant_size_q;
        is_zero_d   = is_zero_q;
        is_nar_d    = is_nar_q;
        done_d      = done_q;
        run_fin     = run_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    word_d      = captured;
                    index_d     = 5'd31;
                    run_d       = '0;
                    exp_cnt_d   = '0;
                    sign_d      = 1'b0;
                    k_d         = '0;
                    exp_d       = '0;
                    mant_d      = '0;
                    mant_size_d = '0;
                    is_zero_d   = 1'b0;
                    is_nar_d    = 1'b0;
                    done_d      = 1'b0;
                    state_d     = ST_SIGN;
                end
            end
            ST_SIGN: begin
                sign_d    = cur_bit;
                pol_d     = word_q[N-2];
                run_d     = '0;
                is_zero_d = (word_q == POSIT_ZERO);
                is_nar_d  = (word_q == POSIT_NAR);
                index_d   = index_q - 5'd1;
                state_d   = ST_REGIME;
            end
            ST_REGIME: begin
                if (cur_bit == pol_q) begin
                    run_d   = run_inc;
                    run_fin = run_inc;
                end
                if ((cur_bit != pol_q) || (index_q == '0)) begin
                    k_d     = pol_q ? (run_fin - 6'd1) : (6'd0 - run_fin);
                    state_d = (index_q == '0) ? ST_DONE : ST_EXP;
                end
                if (index_q != '0) begin
                    index_d = index_q - 5'd1;
                end
            end
            ST_EXP: begin
                case (exp_cnt_q)
                    2'd0:    exp_d[2] = cur_bit;
                    2'd1:    exp_d[1] = cur_bit;
                    default: exp_d[0] = cur_bit;
                endcase
                exp_cnt_d = exp_cnt_q + 2'd1;
                if (index_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q - 5'd1;
                    if (exp_cnt_q == 2'd2) begin
                        state_d = ST_MANT;
                    end
                end
            end
            ST_MANT: begin
                mant_d[5'd31 - mant_size_q] = cur_bit;
                mant_size_d = mant_size_q + 5'd1;
                if (index_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q - 5'd1;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
                // Acknowledge only counts once the consumer can have seen done.
                if (done_q && bus.received) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.sign_out     = sign_q;
    assign bus.k_out        = k_q;
    assign bus.exp_out      = exp_q;
    assign bus.mantissa_out = mant_q;
    assign bus.mant_size    = mant_size_q;
    assign bus.is_zero      = is_zero_q;
    assign bus.is_nar       = is_nar_q;
    assign bus.done         = done_q;
    assign bus.busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_posit_decoder.sv
// tb_posit_decoder: directed and randomized checks of posit_decoder against a
// field-level posit decode model computed with plain arithmetic.
module tb_posit_decoder;
    import posit_pkg::*;

    typedef struct packed {
        logic        sign;
        logic [5:0]  k;
        logic [2:0]  e;
        logic [31:0] m;
        logic [4:0]  ms;
        logic        z;
        logic        n;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    posit_decoder_if bus();

    posit_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(input logic s, input logic [5:0] k, input logic [2:0] e,
                                input logic [31:0] m, input logic [4:0] ms,
                                input logic z, input logic n);
        res_t r;
        r.sign = s; r.k = k; r.e = e; r.m = m; r.ms = ms; r.z = z; r.n = n;
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.sign = bus.sign_out;
        r.k    = bus.k_out;
        r.e    = bus.exp_out;
        r.m    = bus.mantissa_out;
        r.ms   = bus.mant_size;
        r.z    = bus.is_zero;
        r.n    = bus.is_nar;
        return r;
    endfunction

    // Posit decode from the field definitions: regime run, then exponent, then fraction.
    function automatic res_t ref_decode(input logic [31:0] raw);
        res_t        r;
        logic [31:0] w;
        logic [63:0] tail;
        int          run;
        int          rem;
        int          msz;
        w = raw;
`ifdef POSIT_DEC_TWOS_COMP_EN
        begin
            logic [31:0] neg;
            neg = -raw;
            if (raw[31] && raw != 32'h8000_0000) w = {1'b1, neg[30:0]};
        end
`endif
        run = 0;
        while (run < 31 && w[30 - run] == w[30]) run++;
        rem  = (run >= 30) ? 0 : 30 - run;
        tail = {32'd0, w} & ((64'd1 << rem) - 64'd1);
        r.sign = w[31];
        r.k    = w[30] ? 6'(run - 1) : 6'(-run);
        if (rem >= 3) begin
            msz = rem - 3;
            r.e = 3'(tail >> msz);
            r.m = 32'((tail & ((64'd1 << msz) - 64'd1)) << (32 - msz));
        end else begin
            msz = 0;
            r.e = 3'(tail << (3 - rem));
            r.m = 32'd0;
        end
        r.ms = 5'(msz);
        r.z  = (w == 32'd0);
        r.n  = (w == 32'h8000_0000);
        return r;
    endfunction

    // Issue one decode; lat = edges after the accepting edge until done (0 = timeout).
    // pulse_at > 0 raises start and received for one cycle mid-decode.
    task automatic do_decode(input logic [31:0] word, input int pulse_at,
                             output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.posit_in = word;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.posit_in = $urandom;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            bus.start    = 1'b0;
            bus.received = 1'b0;
            if (bus.busy !== (n <= 31)) busy_ok = 1'b0;
            if (bus.done === 1'b1) lat = n;
            if (n == pulse_at) begin
                bus.start    = 1'b1;
                bus.received = 1'b1;
                bus.posit_in = ~word;
            end
        end
    endtask

    task automatic do_release(output logic d, output logic b);
        @(negedge clk);
        bus.received = 1'b1;
        @(posedge clk);
        #1;
        d = bus.done;
        b = bus.busy;
        @(negedge clk);
        bus.received = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.received = 1'b0;
        bus.posit_in = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({observed(), bus.done, bus.busy} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h done=%b busy=%b want all zero",
                     observed(), bus.done, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] words [6];
        res_t        want  [6];
        res_t        act;
        int          lat;
        bit          bok;
        logic        d, b;
        words[0] = 32'h4000_0000; want[0] = mk(1'b0, 6'd0,  3'd0, 32'h0,         5'd26, 1'b0, 1'b0);
        words[1] = 32'h1B60_0000; want[1] = mk(1'b0, 6'h3E, 3'd5, 32'hB000_0000, 5'd25, 1'b0, 1'b0);
        words[2] = 32'h7FFF_FFFF; want[2] = mk(1'b0, 6'd30, 3'd0, 32'h0,         5'd0,  1'b0, 1'b0);
        words[3] = 32'h0000_0000; want[3] = mk(1'b0, 6'h21, 3'd0, 32'h0,         5'd0,  1'b1, 1'b0);
        words[4] = 32'h8000_0000; want[4] = mk(1'b1, 6'h21, 3'd0, 32'h0,         5'd0,  1'b0, 1'b1);
`ifdef POSIT_DEC_TWOS_COMP_EN
        words[5] = 32'hE000_0000; want[5] = mk(1'b1, 6'h3F, 3'd0, 32'h0,         5'd26, 1'b0, 1'b0);
`else
        words[5] = 32'hE000_0000; want[5] = mk(1'b1, 6'd1,  3'd0, 32'h0,         5'd25, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 6; i++) begin
            do_decode(words[i], 0, lat, bok);
            total++;
            if (lat != 33) begin
                bad++;
                $display("FAIL directed_latency word=%h got=%0d want=33", words[i], lat);
            end
            total++;
            if (!bok) begin
                bad++;
                $display("FAIL directed_busy word=%h busy profile wrong, want high for edges 1..31", words[i]);
            end
            act = observed();
            total++;
            if (act !== want[i]) begin
                bad++;
                $display("FAIL directed_fields word=%h got=%h want=%h", words[i], act, want[i]);
            end
            do_release(d, b);
            total++;
            if ({d, b} !== 2'b00) begin
                bad++;
                $display("FAIL directed_release word=%h got done=%b busy=%b want 0 0", words[i], d, b);
            end
        end
    endtask

    task automatic test_handshake();
        res_t snap, want, act;
        int   lat;
        bit   bok;
        logic d, b;
        want = mk(1'b0, 6'h3E, 3'd5, 32'hB000_0000, 5'd25, 1'b0, 1'b0);
        do_decode(32'h1B60_0000, 10, lat, bok);
        total++;
        if (lat != 33 || !bok) begin
            bad++;
            $display("FAIL hs_ignore_start got lat=%0d busy_ok=%0d want lat=33 busy_ok=1", lat, bok);
        end
        snap = observed();
        total++;
        if (snap !== want) begin
            bad++;
            $display("FAIL hs_fields got=%h want=%h", snap, want);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.done !== 1'b1 || observed() !== want) begin
                bad++;
                $display("FAIL hs_hold cycle=%0d got done=%b fields=%h want done=1 fields=%h",
                         c, bus.done, observed(), want);
            end
        end
        do_release(d, b);
        total++;
        if ({d, b} !== 2'b00) begin
            bad++;
            $display("FAIL hs_release got done=%b busy=%b want 0 0", d, b);
        end
        do_decode(32'h4000_0000, 0, lat, bok);
        act = observed();
        total++;
        if (lat != 33 || act !== mk(1'b0, 6'd0, 3'd0, 32'h0, 5'd26, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL hs_restart got lat=%0d fields=%h want lat=33 fields=%h",
                     lat, act, mk(1'b0, 6'd0, 3'd0, 32'h0, 5'd26, 1'b0, 1'b0));
        end
        do_release(d, b);
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa, wb;
        res_t        act;
        int          lat;
        bit          bok;
        logic        d, b;
        wa = 32'h5A5A_1234;
        wb = 32'hC3C3_F00D;
        do_decode(wa, 0, lat, bok);
        act = observed();
        total++;
        if (lat != 33 || act !== ref_decode(wa)) begin
            bad++;
            $display("FAIL b2b_first got lat=%0d fields=%h want lat=33 fields=%h", lat, act, ref_decode(wa));
        end
        @(negedge clk);
        bus.received = 1'b1;
        bus.start    = 1'b1;
        bus.posit_in = wb;
        @(posedge clk);
        #1;
        bus.received = 1'b0;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_received_wins got done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
        do_decode(wb, 0, lat, bok);
        act = observed();
        total++;
        if (lat != 33 || act !== ref_decode(wb)) begin
            bad++;
            $display("FAIL b2b_second got lat=%0d fields=%h want lat=33 fields=%h", lat, act, ref_decode(wb));
        end
        do_release(d, b);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.posit_in = 32'h8F65_4321;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        total++;
        if (bus.sign_out !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre got sign=%b busy=%b want 1 1", bus.sign_out, bus.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({observed(), bus.done, bus.busy} !== '0) begin
            bad++;
            $display("FAIL midrst_clear got=%h done=%b busy=%b want all zero",
                     observed(), bus.done, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        res_t        act, want;
        int          lat;
        bit          bok;
        int          pulse;
        logic        d, b;
        for (int i = 0; i < 50; i++) begin
            w = $urandom;
            case ($urandom_range(0, 2))
                0: ;
                1: w = w >> $urandom_range(1, 31);
                default: begin
                    w     = ~(w >> $urandom_range(1, 31));
                    w[31] = 1'($urandom);
                end
            endcase
            pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0;
            want  = ref_decode(w);
            do_decode(w, pulse, lat, bok);
            act = observed();
            total++;
            if (lat != 33 || !bok || act !== want) begin
                bad++;
                $display("FAIL random[%0d] word=%h got lat=%0d busy_ok=%0d fields=%h want lat=33 busy_ok=1 fields=%h",
                         i, w, lat, bok, act, want);
            end
            do_release(d, b);
            total++;
            if ({d, b} !== 2'b00) begin
                bad++;
                $display("FAIL random_release[%0d] got done=%b busy=%b want 0 0", i, d, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
